adder_subtractor_8bit: RTL and testbench

//   8-bit two's-complement adder/subtractor with a registered result.
//   sel=0 computes A+B; sel=1 computes A-B as A + ~B + 1, using a ripple-carry

---
 rtl/adder_subtractor_8bit.sv | 63 ++++++
 tb/tb_adder_subtractor_8bit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/adder_subtractor_8bit.sv
// 8-bit two's-complement adder/subtractor (ripple-carry) with a registered result.
// Define ADDSUB_OVF_EN to add the registered signed-overflow output V.
module adder_subtractor_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       sel,
  output logic [7:0] S,
`ifdef ADDSUB_OVF_EN
  output logic       cout,
  output logic       V
`else
  output logic       cout
`endif
);

  logic [7:0] bm;
  logic [7:0] sum_d;
  logic [8:0] carry;
  logic [7:0] s_q;
  logic       cout_q;

  // Subtraction reuses the adder: invert B and inject sel as carry-in.
  always_comb begin
    bm       = B ^ {8{sel}};
    sum_d    = '0;
    carry    = '0;
    carry[0] = sel;
    for (int unsigned i = 0; i < 8; i++) begin
      sum_d[i]   = A[i] ^ bm[i] ^ carry[i];
      carry[i+1] = (A[i] & bm[i]) | (A[i] & carry[i]) | (bm[i] & carry[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= sum_d;
      cout_q <= carry[8];
    end
  end

  assign S    = s_q;
  assign cout = cout_q;

`ifdef ADDSUB_OVF_EN
  logic v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else begin
      v_q <= carry[7] ^ carry[8];
    end
  end

  assign V = v_q;
`endif

endmodule

// File: tb/tb_adder_subtractor_8bit.sv
// Self-checking bench for adder_subtractor_8bit; checks V too when ADDSUB_OVF_EN is defined.
module tb_adder_subtractor_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       sel;
  logic [7:0] S;
  logic       cout;
`ifdef ADDSUB_OVF_EN
  logic       V;
`endif

  int checks;
  int failures;

  adder_subtractor_8bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .sel  (sel),
    .S    (S),
`ifdef ADDSUB_OVF_EN
    .cout (cout),
    .V    (V)
`else
    .cout (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {V, cout, S}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int r;
    int sr;
    logic v;
    logic c;
    if (!s) begin
      r  = int'(a) + int'(b);
      sr = int'($signed(a)) + int'($signed(b));
      c  = (r >= 256);
    end else begin
      r  = int'(a) + 256 - int'(b);
      sr = int'($signed(a)) - int'($signed(b));
      c  = (a >= b);
    end
    v = (sr > 127) || (sr < -128);
    model = {v, c, 8'(r % 256)};
  endfunction

  // Drive inputs (caller sits just after an edge), then check one edge later.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [9:0] e;
    A   = a;
    B   = b;
    sel = s;
    e   = model(a, b, s);
    @(posedge clk);
    #1;
    check_eq({tag, ".S"}, S, e[7:0]);
    check_eq({tag, ".cout"}, {7'd0, cout}, {7'd0, e[8]});
`ifdef ADDSUB_OVF_EN
    check_eq({tag, ".V"}, {7'd0, V}, {7'd0, e[9]});
`endif
  endtask

  logic [16:0] vec [0:14];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    sel      = 1'b0;

    // {sel, A, B}
    vec[0]  = {1'b0, 8'h14, 8'hD4};
    vec[1]  = {1'b0, 8'h4C, 8'hD5};
    vec[2]  = {1'b0, 8'h56, 8'hD0};
    vec[3]  = {1'b0, 8'h15, 8'h50};
    vec[4]  = {1'b1, 8'hF4, 8'hD6};
    vec[5]  = {1'b1, 8'h34, 8'h14};
    vec[6]  = {1'b1, 8'h2B, 8'h34};
    vec[7]  = {1'b1, 8'h10, 8'h04};
    vec[8]  = {1'b0, 8'hFF, 8'h01};
    vec[9]  = {1'b1, 8'h00, 8'h01};
    vec[10] = {1'b1, 8'h5A, 8'h5A};
    vec[11] = {1'b0, 8'h7F, 8'h01};
    vec[12] = {1'b1, 8'h80, 8'h01};
    vec[13] = {1'b1, 8'h00, 8'h00};
    vec[14] = {1'b0, 8'h80, 8'h80};

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.S", S, 8'h00);
    check_eq("reset.cout", {7'd0, cout}, 8'h00);
`ifdef ADDSUB_OVF_EN
    check_eq("reset.V", {7'd0, V}, 8'h00);
`endif
    rst_n = 1'b1;

    // Spot-check the documented examples against literal results.
    A = 8'h14; B = 8'hD4; sel = 1'b0;
    @(posedge clk); #1;
    check_eq("lit_add.S", S, 8'hE8);
    check_eq("lit_add.cout", {7'd0, cout}, 8'h00);
    A = 8'h2B; B = 8'h34; sel = 1'b1;
    @(posedge clk); #1;
    check_eq("lit_sub.S", S, 8'hF7);
    check_eq("lit_sub.cout", {7'd0, cout}, 8'h00);
    A = 8'h00; B = 8'h01; sel = 1'b1;
    @(posedge clk); #1;
    check_eq("lit_borrow.S", S, 8'hFF);
    check_eq("lit_borrow.cout", {7'd0, cout}, 8'h00);

    for (int i = 0; i < 15; i++) begin
      logic [16:0] v;
      v = vec[i];
      step($sformatf("dir%0d", i), v[15:8], v[7:0], v[16]);
    end

    // Asynchronous reset mid-cycle with a nonzero result held.
    step("pre_rst", 8'hFF, 8'hFF, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst.S", S, 8'h00);
    check_eq("async_rst.cout", {7'd0, cout}, 8'h00);
`ifdef ADDSUB_OVF_EN
    check_eq("async_rst.V", {7'd0, V}, 8'h00);
`endif
    #2;
    rst_n = 1'b1;
    step("post_rst", 8'h4C, 8'hD5, 1'b0);

    // Back-to-back random operations, a new one every cycle.
    for (int i = 0; i < 1000; i++) begin
      step("rand", 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
